// File: rtl/output_port_allocator_if.sv
// Handshake bundle between the input ports and one output-port allocator.
// The master drives requests and flit flags; the slave (allocator) drives grant/status.
interface output_port_allocator_if #(
  parameter int NUM_IN   = 4,
  parameter int VC_WIDTH = 2
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]          req_i;
  logic [NUM_IN-1:0]          head_i;
  logic [NUM_IN-1:0]          tail_i;
  logic [NUM_IN*VC_WIDTH-1:0] vc_i;
  logic                       out_ready_i;
  logic [NUM_IN-1:0]          grant_o;
  logic [SEL_W-1:0]           sel_o;
  logic                       valid_o;
  logic                       locked_o;
  logic [VC_WIDTH-1:0]        owner_vc_o;

  modport master (
    output req_i, head_i, tail_i, vc_i, out_ready_i,
    input  grant_o, sel_o, valid_o, locked_o, owner_vc_o
  );

  modport slave (
    input  req_i, head_i, tail_i, vc_i, out_ready_i,
    output grant_o, sel_o, valid_o, locked_o, owner_vc_o
  );
endinterface

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin over head flits, locks until tail.
// Define OUT_ALLOC_VC_PRIO_EN to restrict arbitration to the lowest eligible VC id.
module output_port_allocator #(
  parameter int NUM_IN   = 4,
  parameter int VC_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  output_port_allocator_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [VC_WIDTH-1:0] r_owner_vc;

  logic [VC_WIDTH-1:0] w_vc [NUM_IN];
  logic [NUM_IN-1:0]   w_eligible;
  logic [VC_WIDTH-1:0] w_min_vc;
  logic                w_found;
  logic [PTR_W-1:0]    w_winner;
  logic [PTR_W-1:0]    w_sel;
  logic                w_active;
  logic [NUM_IN-1:0]   w_grant;
  logic                w_valid;
  logic                w_xfer;
  logic                w_tail;
  logic [PTR_W-1:0]    w_rr_next;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      w_vc[i] = bus.vc_i[i*VC_WIDTH +: VC_WIDTH];
    end
  end

  always_comb begin
    w_eligible = bus.req_i & bus.head_i;
    w_min_vc   = '1;
`ifdef OUT_ALLOC_VC_PRIO_EN
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (w_eligible[i] && (w_vc[i] < w_min_vc)) w_min_vc = w_vc[i];
    end
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (w_vc[i] != w_min_vc) w_eligible[i] = 1'b0;
    end
`endif
  end

  // Rotating search starting at r_rr_ptr; first hit wins.
  always_comb begin
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = k + 32'(r_rr_ptr);
      if (idx >= 32'(NUM_IN)) idx = idx - 32'(NUM_IN);
      if (!w_found && w_eligible[PTR_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_sel     = (r_state == LOCKED) ? r_owner : w_winner;
    w_active  = arst && ((r_state == LOCKED) || w_found);
    w_grant   = w_active ? (NUM_IN'(1) << w_sel) : '0;
    w_valid   = |(w_grant & bus.req_i);
    w_xfer    = w_valid && bus.out_ready_i;
    w_tail    = bus.tail_i[w_sel];
    w_rr_next = (w_winner == PTR_W'(NUM_IN - 1)) ? '0 : w_winner + 1'b1;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_owner_vc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_rr_ptr   <= w_rr_next;
            r_owner    <= w_winner;
            r_owner_vc <= w_vc[w_winner];
            if (!(w_xfer && w_tail)) r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_xfer && w_tail) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant_o    = w_grant;
  assign bus.sel_o      = w_active ? w_sel : '0;
  assign bus.valid_o    = w_valid;
  assign bus.locked_o   = (r_state == LOCKED);
  assign bus.owner_vc_o = r_owner_vc;
endmodule

// File: tb/tb_output_port_allocator.sv
// Directed vector bench for output_port_allocator (NUM_IN=4, VC_WIDTH=2).
module tb_output_port_allocator;
  logic clk;
  logic arst;
  int   n_checks;
  int   n_fail;

  output_port_allocator_if #(.NUM_IN(4), .VC_WIDTH(2)) bus ();

  output_port_allocator #(.NUM_IN(4), .VC_WIDTH(2)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] head;
    logic [3:0] tail;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       locked;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] head, input logic [3:0] tail,
                       input logic rdy, input logic [7:0] vc);
    bus.req_i       = req;
    bus.head_i      = head;
    bus.tail_i      = tail;
    bus.out_ready_i = rdy;
    bus.vc_i        = vc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00);
    @(negedge clk);
    #2;
    chk("rst_grant", 32'(bus.grant_o), 32'h0);
    chk("rst_locked", 32'(bus.locked_o), 32'h0);
    chk("rst_owner_vc", 32'(bus.owner_vc_o), 32'h0);
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst     = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00);

    //         req      head     tail     rdy   grant    sel   valid locked
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{4'b0101, 4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0101, 4'b0100, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1});
    tbl.push_back('{4'b0101, 4'b0100, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1});
    tbl.push_back('{4'b0101, 4'b0100, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1});
    tbl.push_back('{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{4'b1001, 4'b1001, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1});
    tbl.push_back('{4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1});
    tbl.push_back('{4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1});
    tbl.push_back('{4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});

    do_reset();

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].head, tbl[i].tail, tbl[i].rdy, 8'h00);
      #2;
      chk($sformatf("v%0d_grant", i), 32'(bus.grant_o), 32'(tbl[i].grant));
      chk($sformatf("v%0d_sel", i), 32'(bus.sel_o), 32'(tbl[i].sel));
      chk($sformatf("v%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].valid));
      chk($sformatf("v%0d_locked", i), 32'(bus.locked_o), 32'(tbl[i].locked));
    end

    // VC priority: input 0 on VC 2, input 1 on VC 0, rr_ptr at 0.
    do_reset();
    @(negedge clk);
    drive(4'b0011, 4'b0011, 4'b0011, 1'b1, 8'b00_00_00_10);
    #2;
`ifdef OUT_ALLOC_VC_PRIO_EN
    chk("vcp_grant", 32'(bus.grant_o), 32'h2);
`else
    chk("vcp_grant", 32'(bus.grant_o), 32'h1);
`endif
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 8'b00_00_00_10);
    #2;
    chk("vcp_locked", 32'(bus.locked_o), 32'h0);
`ifdef OUT_ALLOC_VC_PRIO_EN
    chk("vcp_owner_vc", 32'(bus.owner_vc_o), 32'h0);
`else
    chk("vcp_owner_vc", 32'(bus.owner_vc_o), 32'h2);
`endif
    @(negedge clk);
    #2;
`ifdef OUT_ALLOC_VC_PRIO_EN
    chk("vcp_owner_vc_hold", 32'(bus.owner_vc_o), 32'h0);
`else
    chk("vcp_owner_vc_hold", 32'(bus.owner_vc_o), 32'h2);
`endif

    // Reset mid-packet abandons it; later body flits are not granted.
    do_reset();
    @(negedge clk);
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 8'h03);
    #2;
    chk("mid_grant", 32'(bus.grant_o), 32'h1);
    @(negedge clk);
    drive(4'b0001, 4'b0000, 4'b0000, 1'b1, 8'h03);
    #2;
    chk("mid_locked", 32'(bus.locked_o), 32'h1);
    chk("mid_owner_vc", 32'(bus.owner_vc_o), 32'h3);
    #1;
    arst = 1'b0;
    #1;
    chk("inrst_grant", 32'(bus.grant_o), 32'h0);
    chk("inrst_sel", 32'(bus.sel_o), 32'h0);
    chk("inrst_valid", 32'(bus.valid_o), 32'h0);
    chk("inrst_locked", 32'(bus.locked_o), 32'h0);
    chk("inrst_owner_vc", 32'(bus.owner_vc_o), 32'h0);
    @(negedge clk);
    arst = 1'b1;
    #2;
    chk("post_grant", 32'(bus.grant_o), 32'h0);
    chk("post_valid", 32'(bus.valid_o), 32'h0);
    @(negedge clk);
    #2;
    chk("post2_grant", 32'(bus.grant_o), 32'h0);
    chk("post2_locked", 32'(bus.locked_o), 32'h0);
    @(negedge clk);
    drive(4'b0001, 4'b0001, 4'b0001, 1'b1, 8'h03);
    #2;
    chk("recover_grant", 32'(bus.grant_o), 32'h1);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 8'h00);
    #2;
    chk("recover_locked", 32'(bus.locked_o), 32'h0);
    chk("recover_owner_vc", 32'(bus.owner_vc_o), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
